// File: rtl/clock_sim_pkg.sv
// -----------------------------------------------------------------------------
// clock_sim_pkg
// Shared definitions for the clock simulator: the mode state encoding, the
// mode bus width and the default per-digit blanking masks. Digit ordering is
// common to the counter, the display driver and the mode controller:
// bits [3:2] are the minute digits, bits [1:0] are the second digits.
// -----------------------------------------------------------------------------
package clock_sim_pkg;

  localparam int MODE_W   = 2;
  localparam int DIGITS_W = 4;

  typedef enum logic [MODE_W-1:0] {
    RUN     = 2'b00,
    PAUSE   = 2'b01,
    ADJ_MIN = 2'b10,
    ADJ_SEC = 2'b11
  } mode_e;

  // Default blanking patterns (1 = blank that digit)
  localparam logic [DIGITS_W-1:0] MIN_MASK_DEF   = 4'b1100;
  localparam logic [DIGITS_W-1:0] SEC_MASK_DEF   = 4'b0011;
  localparam logic [DIGITS_W-1:0] PAUSE_MASK_DEF = 4'b1111;

  // True for either of the two adjust states
  function automatic logic is_adj(input mode_e m);
    logic r;
    case (m)
      ADJ_MIN: r = 1'b1;
      ADJ_SEC: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// -----------------------------------------------------------------------------
// btn_edge_detect
// Rising-edge detector for a debounced button level. The previous level is
// held in a register that resets to 1, so a button that is already held down
// while reset is released never produces a press. The press output is the
// combination of the live level and the registered history, which lets the
// consuming FSM act on the press at the very next clock edge.
//
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous active-high reset
//   btn    in  1  debounced button level
//   press  out 1  high for exactly one cycle per rising edge of btn
// -----------------------------------------------------------------------------
module btn_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic hist_r;

  // Button history; loaded with 1 on reset to suppress a held-through press
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_r <= 1'b1;
    end else begin
      hist_r <= btn;
    end
  end

  assign press = btn & ~hist_r;

endmodule

// File: rtl/clock_mode_controller.sv
// -----------------------------------------------------------------------------
// clock_mode_controller
// Mode sequencer for the clock simulator. Converts the pause button and the
// adjust/select switches into a four-state mode (RUN, PAUSE, ADJ_MIN,
// ADJ_SEC), issues one-cycle count/increment strobes to the min/sec counter
// and a per-digit blanking mask to the seven-segment driver.
//
// Ports:
//   clk         in  1  system clock, rising edge
//   reset       in  1  synchronous active-high reset
//   tick_1hz    in  1  one-cycle 1 Hz enable
//   tick_2hz    in  1  one-cycle 2 Hz enable
//   tick_4hz    in  1  one-cycle 4 Hz enable (blink rate)
//   pause_btn   in  1  debounced pause button level
//   adjust      in  1  adjust switch (1 = adjust)
//   select      in  1  adjust target (1 = minutes, 0 = seconds)
//   count_en    out 1  advance time by one second
//   min_inc     out 1  increment minutes field
//   sec_inc     out 1  increment seconds field
//   blank_mask  out 4  per-digit blank request, 1 = blank
//   mode        out 2  current state
//   adj_hold    out 1  adjust increments suspended
//
// All outputs are registered. Strobes are decoded from the state held before
// the current edge, so a tick arriving together with a mode change is judged
// against the old mode.
// -----------------------------------------------------------------------------
module clock_mode_controller
  import clock_sim_pkg::*;
#(
  parameter logic [DIGITS_W-1:0] MIN_MASK   = MIN_MASK_DEF,
  parameter logic [DIGITS_W-1:0] SEC_MASK   = SEC_MASK_DEF,
  parameter logic [DIGITS_W-1:0] PAUSE_MASK = PAUSE_MASK_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_1hz,
  input  logic                tick_2hz,
  input  logic                tick_4hz,
  input  logic                pause_btn,
  input  logic                adjust,
  input  logic                select,
  output logic                count_en,
  output logic                min_inc,
  output logic                sec_inc,
  output logic [DIGITS_W-1:0] blank_mask,
  output logic [MODE_W-1:0]   mode,
  output logic                adj_hold
);

  mode_e               state_r;
  mode_e               state_nxt_s;
  logic                press_s;
  logic                adj_hold_r;
  logic                adj_hold_nxt_s;
  logic                phase_r;
  logic                phase_nxt_s;
  logic [DIGITS_W-1:0] blank_mask_r;
  logic [DIGITS_W-1:0] mask_nxt_s;
  logic                count_en_r;
  logic                min_inc_r;
  logic                sec_inc_r;
  logic                count_en_nxt_s;
  logic                min_inc_nxt_s;
  logic                sec_inc_nxt_s;

  btn_edge_detect u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (pause_btn),
    .press (press_s)
  );

  // Next-state decode: adjust overrides everything, otherwise press toggles RUN/PAUSE
  always_comb begin
    state_nxt_s = state_r;
    if (adjust) begin
      if (select) begin
        state_nxt_s = ADJ_MIN;
      end else begin
        state_nxt_s = ADJ_SEC;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (press_s) begin
            state_nxt_s = PAUSE;
          end else begin
            state_nxt_s = RUN;
          end
        end
        PAUSE: begin
          if (press_s) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = PAUSE;
          end
        end
        // Leaving adjust always resumes the clock, never into PAUSE
        ADJ_MIN: state_nxt_s = RUN;
        ADJ_SEC: state_nxt_s = RUN;
        default: state_nxt_s = RUN;
      endcase
    end
  end

  // Hold flag: toggled by a press only while staying inside the adjust states
  always_comb begin
    adj_hold_nxt_s = 1'b0;
    if (adjust && is_adj(state_r)) begin
      adj_hold_nxt_s = adj_hold_r ^ press_s;
    end else begin
      adj_hold_nxt_s = 1'b0;
    end
  end

  // Blink phase: restarts at 0 on every mode change, idles at 0 in RUN
  always_comb begin
    phase_nxt_s = 1'b0;
    if (state_nxt_s != state_r) begin
      phase_nxt_s = 1'b0;
    end else if (state_r == RUN) begin
      phase_nxt_s = 1'b0;
    end else if (tick_4hz) begin
      phase_nxt_s = ~phase_r;
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // Blank mask follows the updated phase and state in the same cycle
  always_comb begin
    mask_nxt_s = 4'b0000;
    if (phase_nxt_s) begin
      case (state_nxt_s)
        PAUSE:   mask_nxt_s = PAUSE_MASK;
        ADJ_MIN: mask_nxt_s = MIN_MASK;
        ADJ_SEC: mask_nxt_s = SEC_MASK;
        default: mask_nxt_s = 4'b0000;
      endcase
    end else begin
      mask_nxt_s = 4'b0000;
    end
  end

  // Strobe decode against the current (pre-update) state; mutually exclusive by state
  always_comb begin
    count_en_nxt_s = tick_1hz & (state_r == RUN);
    min_inc_nxt_s  = tick_2hz & (state_r == ADJ_MIN) & ~adj_hold_r;
    sec_inc_nxt_s  = tick_2hz & (state_r == ADJ_SEC) & ~adj_hold_r;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= RUN;
      adj_hold_r   <= 1'b0;
      phase_r      <= 1'b0;
      blank_mask_r <= 4'b0000;
      count_en_r   <= 1'b0;
      min_inc_r    <= 1'b0;
      sec_inc_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      adj_hold_r   <= adj_hold_nxt_s;
      phase_r      <= phase_nxt_s;
      blank_mask_r <= mask_nxt_s;
      count_en_r   <= count_en_nxt_s;
      min_inc_r    <= min_inc_nxt_s;
      sec_inc_r    <= sec_inc_nxt_s;
    end
  end

  assign mode       = state_r;
  assign adj_hold   = adj_hold_r;
  assign blank_mask = blank_mask_r;
  assign count_en   = count_en_r;
  assign min_inc    = min_inc_r;
  assign sec_inc    = sec_inc_r;

endmodule

// File: tb/tb_clock_mode_controller.sv
// -----------------------------------------------------------------------------
// tb_clock_mode_controller
// Directed vector table covering the mode walk-through, followed by a long
// randomized run compared cycle by cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_clock_mode_controller;

  logic       clk = 1'b0;
  logic       reset, tick_1hz, tick_2hz, tick_4hz, pause_btn, adjust, select;
  logic       count_en, min_inc, sec_inc, adj_hold;
  logic [3:0] blank_mask;
  logic [1:0] mode;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clock_mode_controller dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .tick_2hz   (tick_2hz),
    .tick_4hz   (tick_4hz),
    .pause_btn  (pause_btn),
    .adjust     (adjust),
    .select     (select),
    .count_en   (count_en),
    .min_inc    (min_inc),
    .sec_inc    (sec_inc),
    .blank_mask (blank_mask),
    .mode       (mode),
    .adj_hold   (adj_hold)
  );

  typedef struct {
    logic       rst, t1, t2, t4, btn, adj, sel;
    logic [1:0] mode;
    logic       cnt, mn, sc;
    logic [3:0] mask;
    logic       hold;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int rst, input int t1, input int t2, input int t4,
                              input int btn, input int adj, input int sel,
                              input int md, input int cnt, input int mn, input int sc,
                              input int mask, input int hold);
    vec_t v;
    v.rst = rst[0]; v.t1 = t1[0]; v.t2 = t2[0]; v.t4 = t4[0];
    v.btn = btn[0]; v.adj = adj[0]; v.sel = sel[0];
    v.mode = md[1:0]; v.cnt = cnt[0]; v.mn = mn[0]; v.sc = sc[0];
    v.mask = mask[3:0]; v.hold = hold[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Modes as plain integers: 0 running, 1 paused, 2 adjusting minutes, 3 adjusting seconds.
  int m_mode, m_hold, m_phase, m_prev_btn;
  int e_cnt, e_min, e_sec, e_mask;

  task automatic model_step();
    int old_mode, press;
    if (reset) begin
      m_mode = 0; m_hold = 0; m_phase = 0; m_prev_btn = 1;
      e_cnt = 0; e_min = 0; e_sec = 0; e_mask = 0;
    end else begin
      press      = (pause_btn && !m_prev_btn) ? 1 : 0;
      m_prev_btn = pause_btn ? 1 : 0;
      old_mode   = m_mode;
      e_cnt = (tick_1hz && old_mode == 0) ? 1 : 0;
      e_min = (tick_2hz && old_mode == 2 && m_hold == 0) ? 1 : 0;
      e_sec = (tick_2hz && old_mode == 3 && m_hold == 0) ? 1 : 0;
      if (adjust)             m_mode = select ? 2 : 3;
      else if (old_mode >= 2) m_mode = 0;
      else if (press != 0)    m_mode = 1 - old_mode;
      if (adjust && old_mode >= 2) m_hold = m_hold ^ press;
      else                         m_hold = 0;
      if (m_mode != old_mode || m_mode == 0) m_phase = 0;
      else if (tick_4hz)                     m_phase = 1 - m_phase;
      if (m_phase == 0)      e_mask = 0;
      else if (m_mode == 1)  e_mask = 15;
      else if (m_mode == 2)  e_mask = 12;
      else                   e_mask = 3;
    end
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; tick_2hz = 1'b0; tick_4hz = 1'b0;
    pause_btn = 1'b1; adjust = 1'b0; select = 1'b0;

    //           rst t1 t2 t4 btn adj sel | mode cnt min sec mask hold
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0,  0)); // reset with button held
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0,  0)); // held button: no press
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 0,  0)); // real press -> PAUSE
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 15, 0)); // first blink
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 15, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0,  0)); // press -> RUN, tick ignored in PAUSE
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0,  0)); // count_en
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,  0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0,  0)); // no blink in RUN
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1,   2, 1, 0, 0, 0,  0)); // tick with adjust rise
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1,   2, 0, 1, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1,   2, 0, 0, 0, 12, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 1,   2, 0, 1, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,   3, 0, 0, 0, 0,  0)); // select flip -> ADJ_SEC
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0,   3, 0, 0, 1, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,   3, 0, 0, 0, 0,  1)); // press -> hold
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0,   3, 0, 0, 0, 0,  1)); // held: no sec_inc
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0,   3, 0, 0, 0, 3,  1)); // blink continues
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0,   3, 0, 0, 0, 3,  1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,   3, 0, 0, 0, 3,  0)); // press -> release hold
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0,   3, 0, 0, 1, 3,  0)); // increments resume
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,   3, 0, 0, 0, 3,  1)); // hold again
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0,  0)); // adjust falls while held
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1,   2, 0, 0, 0, 0,  0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 1, 1,   0, 0, 0, 0, 0,  0)); // reset during tick_2hz
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1,   2, 0, 0, 0, 0,  0)); // tick judged against RUN
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,   3, 0, 0, 0, 0,  0)); // press with adjust rise: ignored
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,   3, 0, 0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0,   3, 0, 0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,   3, 0, 0, 0, 0,  1)); // press inside ADJ toggles

    foreach (tbl[i]) begin
      reset = tbl[i].rst; tick_1hz = tbl[i].t1; tick_2hz = tbl[i].t2; tick_4hz = tbl[i].t4;
      pause_btn = tbl[i].btn; adjust = tbl[i].adj; select = tbl[i].sel;
      @(posedge clk); #2;
      check($sformatf("row%0d_mode", i),  {6'd0, mode},       {6'd0, tbl[i].mode});
      check($sformatf("row%0d_cnt", i),   {7'd0, count_en},   {7'd0, tbl[i].cnt});
      check($sformatf("row%0d_min", i),   {7'd0, min_inc},    {7'd0, tbl[i].mn});
      check($sformatf("row%0d_sec", i),   {7'd0, sec_inc},    {7'd0, tbl[i].sc});
      check($sformatf("row%0d_mask", i),  {4'd0, blank_mask}, {4'd0, tbl[i].mask});
      check($sformatf("row%0d_hold", i),  {7'd0, adj_hold},   {7'd0, tbl[i].hold});
    end

    // Randomized run against the model; the first cycle is a reset
    for (int c = 0; c < 4000; c++) begin
      reset    = (c == 0) || ($urandom_range(0, 199) == 0);
      tick_1hz = ($urandom_range(0, 7) == 0);
      tick_2hz = ($urandom_range(0, 3) == 0);
      tick_4hz = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0)  pause_btn = ~pause_btn;
      if ($urandom_range(0, 39) == 0) adjust    = ~adjust;
      if ($urandom_range(0, 14) == 0) select    = ~select;
      @(posedge clk); #2;
      model_step();
      check($sformatf("rnd%0d_mode", c), {6'd0, mode},       8'(m_mode));
      check($sformatf("rnd%0d_cnt", c),  {7'd0, count_en},   8'(e_cnt));
      check($sformatf("rnd%0d_min", c),  {7'd0, min_inc},    8'(e_min));
      check($sformatf("rnd%0d_sec", c),  {7'd0, sec_inc},    8'(e_sec));
      check($sformatf("rnd%0d_mask", c), {4'd0, blank_mask}, 8'(e_mask));
      check($sformatf("rnd%0d_hold", c), {7'd0, adj_hold},   8'(m_hold));
      check($sformatf("rnd%0d_onestrobe", c),
            8'(32'(count_en) + 32'(min_inc) + 32'(sec_inc) > 1), 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
